mem_bus_arbiter: RTL and testbench

// - Shares one single-port synchronous RAM between two picorv32-native-bus requesters:

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 103 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM arbiter: FSM states, port indices and the latched request.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that did not win last time.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       idx
);

  always_comb begin
    idx = 1'(PORT_CPU);
    unique case (req)
      2'b01:   idx = 1'(PORT_CPU);
      2'b10:   idx = 1'(PORT_DMA);
      2'b11:   idx = ~last;
      default: idx = 1'(PORT_CPU);
    endcase
    grant = (req == 2'b00) ? 2'b00 : (idx ? 2'b10 : 2'b01);
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port synchronous RAM between the CPU (port 0) and the
// audio DMA (port 1); one access in flight, round-robin on conflicts.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int RAM_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [1:0]            m_valid,
  input  logic [1:0][31:0]      m_addr,
  input  logic [1:0][31:0]      m_wdata,
  input  logic [1:0][3:0]       m_wstrb,
  output logic [1:0]            m_ready,
  output logic [31:0]           m_rdata,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata,
  output logic [CNT_W-1:0]      conflict_cnt
);

  localparam logic [1:0] WAIT_LOAD = 2'(RAM_LATENCY - 1);

  arb_state_t state;
  logic       last_grant;
  logic       winner;
  logic [1:0] wait_cnt;
  logic [1:0] grant;
  logic       idx;
  req_t       sel;
  logic       unused_addr_bits;

  rr_pick2 u_pick (
    .req   (m_valid),
    .last  (last_grant),
    .grant (grant),
    .idx   (idx)
  );

  always_comb begin
    sel = '{addr: m_addr[idx], wdata: m_wdata[idx], wstrb: m_wstrb[idx]};
  end

  // Byte-offset bits and bits above the RAM size are dropped, so accesses wrap.
  assign unused_addr_bits = ^{sel.addr[31:ADDR_W+2], sel.addr[1:0]};

  // The RAM-side registers double as the request latch: they are loaded once
  // at the grant and ignore the masters until the next grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      winner       <= 1'b0;
      wait_cnt     <= '0;
      m_ready      <= '0;
      m_rdata      <= '0;
      ram_en       <= 1'b0;
      ram_we       <= '0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      conflict_cnt <= '0;
    end else begin
      m_ready <= '0;
      ram_en  <= 1'b0;
      ram_we  <= '0;
      unique case (state)
        IDLE: begin
          if (&m_valid && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + CNT_W'(1);
          if (|grant) begin
            winner     <= idx;
            last_grant <= idx;
            ram_en     <= 1'b1;
            ram_we     <= sel.wstrb;
            ram_addr   <= sel.addr[ADDR_W+1:2];
            ram_wdata  <= sel.wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            m_rdata         <= ram_rdata;
            m_ready[winner] <= 1'b1;
            state           <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: dut_a runs RAM_LATENCY=1 with an 8-bit conflict
// counter, dut_b runs RAM_LATENCY=3; each has its own behavioural RAM.
module tb_mem_bus_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  typedef struct {
    int          d;
    int          p;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [15:0] exp_addr;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          lat;
    int          en_cyc;
    int          en_count;
    logic [15:0] addr;
    logic [3:0]  we;
    logic [31:0] rdata;
    logic [31:0] rdata_hold;
  } obs_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic [1:0]       valid_s     [2];
  logic [1:0][31:0] addr_s      [2];
  logic [1:0][31:0] wdata_s     [2];
  logic [1:0][3:0]  wstrb_s     [2];
  logic [1:0]       ready_s     [2];
  logic [31:0]      rdata_s     [2];
  logic             ram_en_s    [2];
  logic [3:0]       ram_we_s    [2];
  logic [15:0]      ram_addr_s  [2];
  logic [31:0]      ram_wdata_s [2];
  logic [31:0]      ram_rdata_s [2];
  logic [7:0]       cnt_a;
  logic [15:0]      cnt_b;

  logic [31:0] mem  [2][256];
  logic [31:0] pipe [2][3];
  logic [1:0]  vq   [2];
  logic [1:0]  rq   [2];

  int checks = 0;
  int failures = 0;
  int grant_log [$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(16), .RAM_LATENCY(1), .CNT_W(8)) dut_a (
    .clk(clk), .resetn(resetn),
    .m_valid(valid_s[0]), .m_addr(addr_s[0]), .m_wdata(wdata_s[0]), .m_wstrb(wstrb_s[0]),
    .m_ready(ready_s[0]), .m_rdata(rdata_s[0]),
    .ram_en(ram_en_s[0]), .ram_we(ram_we_s[0]), .ram_addr(ram_addr_s[0]),
    .ram_wdata(ram_wdata_s[0]), .ram_rdata(ram_rdata_s[0]),
    .conflict_cnt(cnt_a)
  );

  mem_bus_arbiter #(.ADDR_W(16), .RAM_LATENCY(3), .CNT_W(16)) dut_b (
    .clk(clk), .resetn(resetn),
    .m_valid(valid_s[1]), .m_addr(addr_s[1]), .m_wdata(wdata_s[1]), .m_wstrb(wstrb_s[1]),
    .m_ready(ready_s[1]), .m_rdata(rdata_s[1]),
    .ram_en(ram_en_s[1]), .ram_we(ram_we_s[1]), .ram_addr(ram_addr_s[1]),
    .ram_wdata(ram_wdata_s[1]), .ram_rdata(ram_rdata_s[1]),
    .conflict_cnt(cnt_b)
  );

  function automatic logic [31:0] initWord(input int i);
    case (i)
      2:       return 32'hAABB_CCDD;
      16:      return 32'hDEAD_BEEF;
      default: return 32'h1000_0000 + 32'(i);
    endcase
  endfunction

  // RAM models; read data is only meaningful exactly RAM_LATENCY cycles after ram_en.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 256; i++) mem[d][i] <= initWord(i);
        for (int s = 0; s < 3; s++) pipe[d][s] <= JUNK;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (ram_en_s[d])
          for (int b = 0; b < 4; b++)
            if (ram_we_s[d][b])
              mem[d][ram_addr_s[d][7:0]][8*b +: 8] <= ram_wdata_s[d][8*b +: 8];
        pipe[d][0] <= ram_en_s[d] ? mem[d][ram_addr_s[d][7:0]] : JUNK;
        pipe[d][1] <= pipe[d][0];
        pipe[d][2] <= pipe[d][1];
      end
    end
  end

  assign ram_rdata_s[0] = pipe[0][0];
  assign ram_rdata_s[1] = pipe[1][2];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int d = 0; d < 2; d++) begin
        vq[d] <= '0;
        rq[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++)
          assert (!(vq[d][p] && !rq[d][p] && !valid_s[d][p]))
            else $error("[TB] FAIL protocol dut%0d port%0d dropped valid before ready", d, p);
        assert (ready_s[d] != 2'b11)
          else $error("[TB] FAIL both_ready dut%0d got=%b", d, ready_s[d]);
        vq[d] <= valid_s[d];
        rq[d] <= ready_s[d];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // One single-port transaction; inputs are scrambled after the grant to prove latching.
  task automatic applyStimulus(input int d, input int p, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] ws, output obs_t o);
    o.lat = -1; o.en_cyc = -1; o.en_count = 0;
    o.addr = '0; o.we = '0; o.rdata = '0; o.rdata_hold = '0;
    @(posedge clk); #1;
    addr_s[d][p] = a; wdata_s[d][p] = wd; wstrb_s[d][p] = ws; valid_s[d][p] = 1'b1;
    for (int c = 0; c <= 20 && o.lat < 0; c++) begin
      @(negedge clk);
      if (ram_en_s[d]) begin
        o.en_count++;
        if (o.en_cyc < 0) begin
          o.en_cyc = c; o.addr = ram_addr_s[d]; o.we = ram_we_s[d];
        end
      end
      if (ready_s[d][p]) begin
        o.lat = c; o.rdata = rdata_s[d];
      end
      if (c == 1) begin
        addr_s[d][p] = ~a; wdata_s[d][p] = ~wd; wstrb_s[d][p] = ~ws;
      end
    end
    @(posedge clk); #1;
    valid_s[d][p] = 1'b0;
    @(negedge clk);
    o.rdata_hold = rdata_s[d];
  endtask

  // Both dut_a ports request; each re-requests after ready until the last two grants.
  task automatic driveConflicts(input int n, output int got);
    logic [1:0] drop;
    int k;
    k = 0;
    grant_log.delete();
    @(posedge clk); #1;
    addr_s[0][0] = 32'h40; addr_s[0][1] = 32'h8;
    wstrb_s[0][0] = 4'h0; wstrb_s[0][1] = 4'h0;
    valid_s[0] = 2'b11;
    for (int cyc = 0; cyc < n * 8 + 20 && k < n; cyc++) begin
      @(negedge clk);
      drop = '0;
      for (int p = 0; p < 2; p++)
        if (ready_s[0][p]) begin
          grant_log.push_back(p);
          if (k >= n - 2) drop[p] = 1'b1;
          k++;
        end
      @(posedge clk); #1;
      valid_s[0] = valid_s[0] & ~drop;
    end
    valid_s[0] = '0;
    got = k;
  endtask

  initial begin
    vec_t vecs [12];
    obs_t o;
    int   got;
    int   seen;

    for (int d = 0; d < 2; d++) begin
      valid_s[d] = '0; addr_s[d] = '0; wdata_s[d] = '0; wstrb_s[d] = '0;
    end

    vecs[0]  = '{0, 1, 32'h0000_0008, 32'h1234_5678, 4'b0011, 16'h0002, 1'b0, 32'h0,         3};
    vecs[1]  = '{0, 0, 32'h0000_0008, 32'h0,         4'b0000, 16'h0002, 1'b1, 32'hAABB_5678, 3};
    vecs[2]  = '{0, 0, 32'h0000_0040, 32'h0,         4'b0000, 16'h0010, 1'b1, 32'hDEAD_BEEF, 3};
    vecs[3]  = '{0, 0, 32'h0004_0040, 32'h0,         4'b0000, 16'h0010, 1'b1, 32'hDEAD_BEEF, 3};
    vecs[4]  = '{0, 0, 32'h0000_0044, 32'hCAFE_F00D, 4'b1111, 16'h0011, 1'b0, 32'h0,         3};
    vecs[5]  = '{0, 1, 32'h0000_0044, 32'h0,         4'b0000, 16'h0011, 1'b1, 32'hCAFE_F00D, 3};
    vecs[6]  = '{0, 0, 32'h0000_0044, 32'h1100_0000, 4'b1000, 16'h0011, 1'b0, 32'h0,         3};
    vecs[7]  = '{0, 1, 32'h0000_0047, 32'h0,         4'b0000, 16'h0011, 1'b1, 32'h11FE_F00D, 3};
    vecs[8]  = '{1, 0, 32'h0000_0040, 32'h0,         4'b0000, 16'h0010, 1'b1, 32'hDEAD_BEEF, 5};
    vecs[9]  = '{1, 1, 32'h0000_0008, 32'h0,         4'b0000, 16'h0002, 1'b1, 32'hAABB_CCDD, 5};
    vecs[10] = '{1, 1, 32'h0000_000C, 32'h0000_00EE, 4'b0001, 16'h0003, 1'b0, 32'h0,         5};
    vecs[11] = '{1, 0, 32'h0000_000C, 32'h0,         4'b0000, 16'h0003, 1'b1, 32'h1000_00EE, 5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset_ready%0d", d),   32'(ready_s[d]),    32'h0);
      checkOutput($sformatf("reset_rdata%0d", d),   rdata_s[d],         32'h0);
      checkOutput($sformatf("reset_ram_en%0d", d),  32'(ram_en_s[d]),   32'h0);
      checkOutput($sformatf("reset_ram_we%0d", d),  32'(ram_we_s[d]),   32'h0);
      checkOutput($sformatf("reset_ram_addr%0d", d), 32'(ram_addr_s[d]), 32'h0);
      checkOutput($sformatf("reset_ram_wdata%0d", d), ram_wdata_s[d],   32'h0);
    end
    checkOutput("reset_conflict_a", 32'(cnt_a), 32'h0);
    checkOutput("reset_conflict_b", 32'(cnt_b), 32'h0);
    resetn = 1'b1;

    driveConflicts(2, got);
    checkOutput("conflict_grants", 32'(got), 32'd2);
    checkOutput("conflict_first",  32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
    checkOutput("conflict_second", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd1);
    checkOutput("conflict_cnt1",   32'(cnt_a), 32'd1);

    driveConflicts(4, got);
    checkOutput("alt_grants", 32'(got), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("alt_order%0d", i),
                  32'(grant_log.size() > i ? grant_log[i] : -1), 32'(i % 2));
    checkOutput("alt_conflict_cnt", 32'(cnt_a), 32'd4);

    driveConflicts(267, got);
    checkOutput("sat_grants", 32'(got), 32'd267);
    checkOutput("sat_conflict_cnt", 32'(cnt_a), 32'h0000_00FF);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].d, vecs[i].p, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, o);
      checkOutput($sformatf("row%0d_latency", i),  32'(o.lat),      32'(vecs[i].exp_lat));
      checkOutput($sformatf("row%0d_en_cycle", i), 32'(o.en_cyc),   32'd1);
      checkOutput($sformatf("row%0d_en_count", i), 32'(o.en_count), 32'd1);
      checkOutput($sformatf("row%0d_ram_addr", i), 32'(o.addr),     32'(vecs[i].exp_addr));
      checkOutput($sformatf("row%0d_ram_we", i),   32'(o.we),       32'(vecs[i].wstrb));
      if (vecs[i].chk_rd) begin
        checkOutput($sformatf("row%0d_rdata", i),      o.rdata,      vecs[i].exp_rd);
        checkOutput($sformatf("row%0d_rdata_hold", i), o.rdata_hold, vecs[i].exp_rd);
      end
    end

    // Reset while dut_b sits in WAIT: no ready for the aborted read.
    seen = 0;
    @(posedge clk); #1;
    addr_s[1][0] = 32'h44; wstrb_s[1][0] = 4'h0; valid_s[1][0] = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_ready",    32'(ready_s[1]),    32'h0);
    checkOutput("midrst_ram_en",   32'(ram_en_s[1]),   32'h0);
    checkOutput("midrst_rdata",    rdata_s[1],         32'h0);
    checkOutput("midrst_ram_addr", 32'(ram_addr_s[1]), 32'h0);
    checkOutput("midrst_cnt_a",    32'(cnt_a),         32'h0);
    valid_s[1][0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready_s[1] != 2'b00 || ram_en_s[1]) seen++;
    end
    checkOutput("midrst_quiet", 32'(seen), 32'd0);
    resetn = 1'b1;

    applyStimulus(1, 0, 32'h0000_0044, 32'h0, 4'h0, o);
    checkOutput("postrst_latency",  32'(o.lat),    32'd5);
    checkOutput("postrst_en_cycle", 32'(o.en_cyc), 32'd1);
    checkOutput("postrst_rdata",    o.rdata,       32'h1000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
